diy_mole_recorder: RTL and testbench
====================================

DIY_MOLE_RECORDER -- requirements
Module: diy_mole_recorder

Interface
REQ-001 Parameter INDEX_BITS, default 8: width of mole index and count.
REQ-002 Parameter MAX_ITEM, default 8'd127: highest storable index, so depth is MAX_ITEM+1 entries.
REQ-003 Port clk, input, 1: single system clock (27 MHz).
REQ-004 Port reset, input, 1: reset, asynchronous and active-low.
REQ-005 Port record_enable, input, 1: high while the game FSM is in RECORD_DIY_IN_PROGRESS.
REQ-006 Port music_address, input, 23: current audio playback address.
REQ-007 Port pads, input, 8: debounced pad levels, ordered {upleft, up, upright, left, right, downleft, down, downright}; bit 7 is location 0.
REQ-008 Port stop_request, input, 1: single-cycle pulse requesting the end of recording.
REQ-009 Port lookup_index, input, INDEX_BITS: playback read index from the mole timing stage.
REQ-010 Port index_address, output, 23: stored music address at lookup_index.
REQ-011 Port saved_mole_location, output, 3: stored location at lookup_index.
REQ-012 Port total_moles, output, INDEX_BITS: number of valid entries.
REQ-013 Port ready_to_use, output, 1: a recording is complete and usable.
REQ-014 Port full, output, 1: the entry count has reached MAX_ITEM+1.

Function
REQ-015 States SHALL be IDLE, WAIT_RELEASE, ARMED, WRITE and DONE.
REQ-016 IDLE: when record_enable goes high, the block SHALL clear total_moles and ready_to_use and go to WAIT_RELEASE.
REQ-017 WAIT_RELEASE: when pads==0, the block SHALL go to ARMED.
REQ-018 ARMED: a valid capture SHALL be a pads value that is exactly one-hot and differs from the previous cycle's pads==0 sample (rising edge from all-released).
REQ-019 On a valid capture, the block SHALL latch music_address and the one-hot-to-binary location (bit7 gives 0 ... bit0 gives 7) and go to WRITE.
REQ-020 A non-one-hot press (two or more pads) SHALL be ignored and the block SHALL go to WAIT_RELEASE.
REQ-021 WRITE: the block SHALL store {address, location} at index total_moles, increment total_moles, then go to WAIT_RELEASE, or to DONE if the new count equals MAX_ITEM+1.
REQ-022 A capture whose address is less than or equal to the previous stored address SHALL be discarded, with no write and no count change.
REQ-023 A write SHALL occupy exactly one cycle; captures SHALL be accepted at most once per press.
REQ-024 stop_request in WAIT_RELEASE or ARMED SHALL move the block to DONE only if total_moles is at least 1; otherwise it SHALL be ignored.
REQ-025 stop_request in the same cycle as a valid capture SHALL give priority to the capture; the stop SHALL be dropped, and the user re-issues it.
REQ-026 record_enable going low in any state other than DONE SHALL return the block to IDLE with total_moles=0.
REQ-027 DONE: ready_to_use=1 and entries SHALL be held until the next record_enable rising edge in IDLE.
REQ-028 In DONE, record_enable going low SHALL move the block to IDLE while retaining entries, total_moles and ready_to_use.
REQ-029 Reads SHALL be registered with 1-cycle latency: index_address and saved_mole_location in cycle N+1 reflect lookup_index at cycle N.
REQ-030 When lookup_index is greater than or equal to total_moles, the read SHALL return entry 0; when total_moles==0, it SHALL return 23'h0 and 3'd0.
REQ-031 full SHALL equal (total_moles == MAX_ITEM+1), and the total_moles width SHALL hold that value without wrap.
REQ-032 Storage SHALL be synchronous-write memory; contents SHALL not be reset.

Reset
REQ-033 On reset low, asynchronously: state=IDLE, total_moles=0, ready_to_use=0, full=0, index_address=0, saved_mole_location=0, and all capture and edge registers cleared.
REQ-034 Reset low mid-WRITE SHALL abort the write and leave the count at 0.
REQ-035 Operation SHALL resume on the first clk edge after reset goes high.

Verification
REQ-036 Scenario: record_enable=1; press pads=8'b0010_0000 at music_address=23'h8B00; release; press 8'b0000_0001 at 23'hE900; pulse stop_request -> total_moles=2 and ready_to_use=1; lookup_index=1 gives 23'hE900 and location 7 one cycle later.
REQ-037 Scenario: press pads=8'b1100_0000 -> no write and total_moles unchanged; a single-pad press after release is then accepted.
REQ-038 Scenario: with MAX_ITEM=3, make four valid captures -> full=1, ready_to_use=1, state DONE; a fifth press is ignored.
REQ-039 Scenario: a second capture at the same music_address as the first -> discarded, and total_moles stays 1.
REQ-040 Scenario: stop_request with zero entries -> no DONE; record_enable dropped mid-recording -> total_moles=0.
REQ-041 Scenario: reset asserted during DONE -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/diy_mole_recorder.sv
// DIY mole recorder: captures single-pad presses against the music address
// while recording, and serves the stored table to the playback stage.
module diy_mole_recorder #(
  parameter int INDEX_BITS = 8,
  parameter int MAX_ITEM   = 8'd127
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  record_enable,
  input  logic [22:0]           music_address,
  input  logic [7:0]            pads,
  input  logic                  stop_request,
  input  logic [INDEX_BITS-1:0] lookup_index,
  output logic [22:0]           index_address,
  output logic [2:0]            saved_mole_location,
  output logic [INDEX_BITS-1:0] total_moles,
  output logic                  ready_to_use,
  output logic                  full
);

  localparam int DEPTH = MAX_ITEM + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [INDEX_BITS-1:0] COUNT_FULL = INDEX_BITS'(DEPTH);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_RELEASE = 3'd1,
    ARMED        = 3'd2,
    WRITE        = 3'd3,
    DONE         = 3'd4
  } state_t;

  state_t                  r_state;
  logic [INDEX_BITS-1:0]   r_total;
  logic                    r_ready;
  logic [22:0]             r_cap_addr;
  logic [2:0]              r_cap_loc;
  logic [22:0]             r_last_addr;
  logic                    r_rec_en_d;
  logic                    r_pads_zero_d;
  logic [22:0]             r_index_address;
  logic [2:0]              r_saved_loc;
  logic [22:0]             r_mem_addr [DEPTH];
  logic [2:0]              r_mem_loc  [DEPTH];

  logic                    w_rec_rise;
  logic                    w_pads_zero;
  logic                    w_onehot;
  logic                    w_capture;
  logic                    w_stop_ok;
  logic                    w_discard;
  logic                    w_write;
  logic [INDEX_BITS-1:0]   w_next_total;
  logic [2:0]              w_loc;
  logic [AW-1:0]           w_wr_idx;
  logic [AW-1:0]           w_rd_idx;

  assign w_rec_rise   = record_enable & ~r_rec_en_d;
  assign w_pads_zero  = (pads == 8'h00);
  assign w_onehot     = $onehot(pads);
  assign w_capture    = w_onehot & r_pads_zero_d;
  assign w_stop_ok    = stop_request & (r_total != '0);
  // Non-increasing addresses would break the playback ordering, so drop them.
  assign w_discard    = (r_total != '0) && (r_cap_addr <= r_last_addr);
  assign w_write      = (r_state == WRITE) && record_enable && !w_discard;
  assign w_next_total = r_total + 1'b1;
  assign w_wr_idx     = r_total[AW-1:0];
  assign w_rd_idx     = (lookup_index >= r_total) ? '0 : lookup_index[AW-1:0];

  // Pad bit 7 is location 0 down to bit 0 as location 7.
  always_comb begin
    w_loc = 3'd0;
    case (pads)
      8'b1000_0000: w_loc = 3'd0;
      8'b0100_0000: w_loc = 3'd1;
      8'b0010_0000: w_loc = 3'd2;
      8'b0001_0000: w_loc = 3'd3;
      8'b0000_1000: w_loc = 3'd4;
      8'b0000_0100: w_loc = 3'd5;
      8'b0000_0010: w_loc = 3'd6;
      8'b0000_0001: w_loc = 3'd7;
      default:      w_loc = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_total       <= '0;
      r_ready       <= 1'b0;
      r_cap_addr    <= '0;
      r_cap_loc     <= '0;
      r_last_addr   <= '0;
      r_rec_en_d    <= 1'b0;
      r_pads_zero_d <= 1'b0;
    end else begin
      r_rec_en_d    <= record_enable;
      r_pads_zero_d <= w_pads_zero;
      case (r_state)
        IDLE: begin
          if (w_rec_rise) begin
            r_total     <= '0;
            r_ready     <= 1'b0;
            r_last_addr <= '0;
            r_state     <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!record_enable) begin
            r_total <= '0;
            r_state <= IDLE;
          end else if (w_stop_ok) begin
            r_ready <= 1'b1;
            r_state <= DONE;
          end else if (w_pads_zero) begin
            r_state <= ARMED;
          end
        end
        ARMED: begin
          if (!record_enable) begin
            r_total <= '0;
            r_state <= IDLE;
          end else if (w_capture) begin
            // A stop in the same cycle is dropped in favour of the capture.
            r_cap_addr <= music_address;
            r_cap_loc  <= w_loc;
            r_state    <= WRITE;
          end else if (w_stop_ok) begin
            r_ready <= 1'b1;
            r_state <= DONE;
          end else if (!w_pads_zero) begin
            r_state <= WAIT_RELEASE;
          end
        end
        WRITE: begin
          if (!record_enable) begin
            r_total <= '0;
            r_state <= IDLE;
          end else if (w_discard) begin
            r_state <= WAIT_RELEASE;
          end else begin
            r_total     <= w_next_total;
            r_last_addr <= r_cap_addr;
            if (w_next_total == COUNT_FULL) begin
              r_ready <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= WAIT_RELEASE;
            end
          end
        end
        DONE: begin
          if (!record_enable) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem_addr[w_wr_idx] <= r_cap_addr;
      r_mem_loc[w_wr_idx]  <= r_cap_loc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_index_address <= '0;
      r_saved_loc     <= '0;
    end else if (r_total == '0) begin
      r_index_address <= '0;
      r_saved_loc     <= '0;
    end else begin
      r_index_address <= r_mem_addr[w_rd_idx];
      r_saved_loc     <= r_mem_loc[w_rd_idx];
    end
  end

  assign index_address       = r_index_address;
  assign saved_mole_location = r_saved_loc;
  assign total_moles         = r_total;
  assign ready_to_use        = r_ready;
  assign full                = (r_total == COUNT_FULL);

endmodule

// File: tb/tb_diy_mole_recorder.sv
// Self-checking bench for diy_mole_recorder: directed scenarios plus a random
// fill, compared against a queue-based model of the recorded table.
module tb_diy_mole_recorder;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        record_enable;
  logic [22:0] music_address;
  logic [7:0]  pads;
  logic        stop_request;
  logic [7:0]  lookup_index;
  logic [22:0] index_address;
  logic [2:0]  saved_mole_location;
  logic [7:0]  total_moles;
  logic        ready_to_use;
  logic        full;

  diy_mole_recorder dut (
    .clk                 (clk),
    .reset               (reset),
    .record_enable       (record_enable),
    .music_address       (music_address),
    .pads                (pads),
    .stop_request        (stop_request),
    .lookup_index        (lookup_index),
    .index_address       (index_address),
    .saved_mole_location (saved_mole_location),
    .total_moles         (total_moles),
    .ready_to_use        (ready_to_use),
    .full                (full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = idle, 1 = recording, 2 = done.
  int          m_mode  = 0;
  logic        m_ready = 1'b0;
  logic [22:0] q_addr[$];
  logic [2:0]  q_loc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] loc_of(input logic [7:0] p);
    logic [2:0] l;
    l = 3'd0;
    for (int k = 0; k < 8; k++) if (p[k]) l = 3'(7 - k);
    return l;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_ready = 1'b0;
    q_addr.delete();
    q_loc.delete();
  endtask

  task automatic set_enable(input logic v);
    record_enable = v;
    step(1);
    if (!v) begin
      if (m_mode == 1) begin
        q_addr.delete();
        q_loc.delete();
      end
      m_mode = 0;
    end else if (m_mode == 0) begin
      q_addr.delete();
      q_loc.delete();
      m_ready = 1'b0;
      m_mode = 1;
    end
    step(1);
  endtask

  task automatic press(input logic [7:0] p, input logic [22:0] a, input logic s);
    pads = 8'h00;
    step(2);
    pads = p;
    music_address = a;
    stop_request = s;
    step(1);
    stop_request = 1'b0;
    step(1);
    pads = 8'h00;
    step(1);
    if (m_mode == 1) begin
      if ($countones(p) == 1) begin
        if (q_addr.size() == 0 || a > q_addr[q_addr.size()-1]) begin
          q_addr.push_back(a);
          q_loc.push_back(loc_of(p));
          if (q_addr.size() == DEPTH) begin
            m_mode = 2;
            m_ready = 1'b1;
          end
        end
      end else if (s && q_addr.size() >= 1) begin
        m_mode = 2;
        m_ready = 1'b1;
      end
    end
  endtask

  task automatic stop_pulse();
    stop_request = 1'b1;
    step(1);
    stop_request = 1'b0;
    step(1);
    if (m_mode == 1 && q_addr.size() >= 1) begin
      m_mode = 2;
      m_ready = 1'b1;
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".total"}, 32'(total_moles), 32'(q_addr.size()));
    chk({tag, ".ready"}, 32'(ready_to_use), 32'(m_ready));
    chk({tag, ".full"},  32'(full), 32'(q_addr.size() == DEPTH));
  endtask

  task automatic check_read(input logic [7:0] idx);
    logic [22:0] ea;
    logic [2:0]  el;
    lookup_index = idx;
    step(1);
    if (q_addr.size() == 0) begin
      ea = '0;
      el = '0;
    end else if (int'(idx) >= q_addr.size()) begin
      ea = q_addr[0];
      el = q_loc[0];
    end else begin
      ea = q_addr[idx];
      el = q_loc[idx];
    end
    chk("read.addr", 32'(index_address), 32'(ea));
    chk("read.loc",  32'(saved_mole_location), 32'(el));
  endtask

  initial begin
    logic [22:0] addr;
    logic [7:0]  p;
    int          n;

    reset = 1'b0;
    record_enable = 1'b0;
    music_address = '0;
    pads = 8'h00;
    stop_request = 1'b0;
    lookup_index = '0;
    model_reset();
    step(3);
    chk("rst.total", 32'(total_moles), 32'd0);
    chk("rst.ready", 32'(ready_to_use), 32'd0);
    chk("rst.full",  32'(full), 32'd0);
    chk("rst.addr",  32'(index_address), 32'd0);
    chk("rst.loc",   32'(saved_mole_location), 32'd0);
    reset = 1'b1;
    step(2);

    // Two-entry recording ended by stop.
    set_enable(1'b1);
    press(8'b0010_0000, 23'h8B00, 1'b0);
    press(8'b0000_0001, 23'hE900, 1'b0);
    stop_pulse();
    chk("basic.total", 32'(total_moles), 32'd2);
    chk("basic.ready", 32'(ready_to_use), 32'd1);
    check_read(8'd1);
    chk("basic.loc7", 32'(saved_mole_location), 32'd7);
    check_read(8'd0);
    check_read(8'd5);

    // Leaving DONE keeps the table; a new enable clears it.
    set_enable(1'b0);
    check_status("done_drop");
    check_read(8'd1);
    set_enable(1'b1);
    check_status("rearm");
    check_read(8'd0);

    // Multi-pad press ignored, then a single press accepted.
    press(8'b1100_0000, 23'h0100, 1'b0);
    check_status("multi");
    press(8'b0100_0000, 23'h0200, 1'b0);
    check_status("single_after");
    // Same address as the last stored entry is discarded.
    press(8'b0000_1000, 23'h0200, 1'b0);
    check_status("same_addr");
    // Stop coinciding with a capture: capture wins, stop dropped.
    press(8'b0000_0100, 23'h0300, 1'b1);
    check_status("stop_vs_capture");
    chk("stop_vs_capture.total2", 32'(total_moles), 32'd2);
    check_read(8'd1);

    // Dropping enable mid-recording zeroes the count.
    set_enable(1'b0);
    check_status("drop_mid");
    chk("drop_mid.zero", 32'(total_moles), 32'd0);
    check_read(8'd0);
    // Stop with no entries does nothing.
    set_enable(1'b1);
    stop_pulse();
    check_status("stop_empty");
    chk("stop_empty.ready", 32'(ready_to_use), 32'd0);

    // Random fill to full.
    addr = 23'h000100;
    n = 0;
    while (m_mode == 1 && n < 400) begin
      if ($urandom_range(0, 99) < 85) p = 8'h01 << $urandom_range(0, 7);
      else begin
        do p = 8'($urandom); while ($countones(p) < 2);
      end
      if ($urandom_range(0, 99) < 5) addr = (addr > 23'd100) ? addr - 23'd100 : 23'd0;
      else addr = addr + 23'($urandom_range(0, 40));
      press(p, addr, 1'b0);
      check_status("rand");
      n++;
    end
    chk("rand.full",  32'(full), 32'd1);
    chk("rand.ready", 32'(ready_to_use), 32'd1);
    press(8'b1000_0000, 23'h7FFFFF, 1'b0);
    check_status("press_after_full");
    for (int i = 0; i < 24; i++) check_read(8'($urandom_range(0, 255)));
    check_read(8'd127);
    check_read(8'd128);

    // Asynchronous reset during DONE.
    reset = 1'b0;
    #1;
    model_reset();
    chk("async.total", 32'(total_moles), 32'd0);
    chk("async.ready", 32'(ready_to_use), 32'd0);
    chk("async.full",  32'(full), 32'd0);
    chk("async.addr",  32'(index_address), 32'd0);
    chk("async.loc",   32'(saved_mole_location), 32'd0);
    record_enable = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);

    // Reset while the write is pending aborts it.
    set_enable(1'b1);
    pads = 8'h00;
    step(2);
    pads = 8'b0001_0000;
    music_address = 23'h4000;
    step(1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("wr_abort.total", 32'(total_moles), 32'd0);
    pads = 8'h00;
    record_enable = 1'b0;
    step(1);
    reset = 1'b1;
    step(2);
    check_status("wr_abort.after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
